i2s_tx: RTL and testbench

Left-justified serial audio transmitter that drives the CS4272 codec's `SDin` from the equalizer's post-volume left/right samples. It also generates the codec clocks (`MCLK`, `SCLK`, `LRCLK`) and the codec reset `RSTn` from one free-running frame counter. A one-deep holding buffer with a valid/ready handshake decouples the DSP datapath from the frame schedule. It is the transmit-side counterpart of the block that deserializes `SDout`, and shares its frame timing.

---
 rtl/i2s_tx.sv | 131 +++++++++++++
 tb/tb_i2s_tx.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// Left-justified I2S-style transmitter for the CS4272: codec clocks, codec reset and SDin from a 10-bit frame counter.
// Optional I2S_TX_HOLD_LAST_EN: on underrun repeat the last loaded pair instead of sending silence.
module i2s_tx #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] lft_in,
  input  logic [DW-1:0] rht_in,
  input  logic          smpl_vld,
  output logic          smpl_rdy,
  output logic          MCLK,
  output logic          SCLK,
  output logic          LRCLK,
  output logic          SDin,
  output logic          RSTn,
  output logic          frm_strt,
  output logic          undr
);

  localparam int unsigned CW = 10;
  localparam int unsigned SW = 2 * DW;
  localparam logic [CW-1:0] LOAD_CNT = CW'(10'h1FF);
  localparam logic [CW-1:0] WRAP_CNT = CW'(10'h3FF);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt;
  logic            rstn_q;
  logic            frm_q;
  logic            undr_q;
  logic [DW-1:0]   hold_l, hold_r;
  logic [SW-1:0]   shreg;
  logic [SW-1:0]   load_word;
  logic [SW-1:0]   undr_word;
  logic            load;
  logic            shift;
  logic            hold_en;
  logic            empty_miss;

  // Loads happen once per frame, just before LRCLK rises, and only after the codec is out of reset.
  assign load  = rstn_q && (cnt == LOAD_CNT);
  assign shift = (cnt[4:0] == 5'h1F) && (cnt != LOAD_CNT);

  // Holding buffer state machine.
  always_comb begin
    state_d = state_q;
    hold_en = 1'b0;
    if (state_q == S_EMPTY) begin
      if (smpl_vld && !load) begin
        state_d = S_FULL;
        hold_en = 1'b1;
      end
    end else if (load) begin
      state_d = S_EMPTY;
    end
  end

  // Word for the next frame: buffered pair, bypassed input pair, or underrun fill.
  always_comb begin
    load_word  = undr_word;
    empty_miss = 1'b0;
    if (state_q == S_FULL) begin
      load_word = {hold_l, hold_r};
    end else if (smpl_vld) begin
      load_word = {lft_in, rht_in};
    end else begin
      empty_miss = 1'b1;
    end
  end

`ifdef I2S_TX_HOLD_LAST_EN
  logic [SW-1:0] last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
    end else if (load) begin
      last_q <= load_word;
    end
  end

  assign undr_word = last_q;
`else
  assign undr_word = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      rstn_q  <= 1'b0;
      state_q <= S_EMPTY;
      hold_l  <= '0;
      hold_r  <= '0;
      shreg   <= '0;
      frm_q   <= 1'b0;
      undr_q  <= 1'b0;
    end else begin
      cnt     <= cnt + CW'(1);
      state_q <= state_d;
      frm_q   <= load;
      undr_q  <= load && empty_miss;
      if (cnt == WRAP_CNT) begin
        rstn_q <= 1'b1;
      end
      if (hold_en) begin
        hold_l <= lft_in;
        hold_r <= rht_in;
      end
      if (load) begin
        shreg <= load_word;
      end else if (shift) begin
        shreg <= {shreg[SW-2:0], 1'b0};
      end
    end
  end

  assign smpl_rdy = (state_q == S_EMPTY);
  assign MCLK     = cnt[1];
  assign SCLK     = cnt[4];
  assign LRCLK    = cnt[9];
  assign SDin     = shreg[SW-1];
  assign RSTn     = rstn_q;
  assign frm_strt = frm_q;
  assign undr     = undr_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: frame-level reference model, SDin decoded at SCLK rises.
module tb_i2s_tx;
  localparam int unsigned DW = 16;
`ifdef I2S_TX_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] lft_in = '0;
  logic [DW-1:0] rht_in = '0;
  logic          smpl_vld = 1'b0;
  logic          smpl_rdy, MCLK, SCLK, LRCLK, SDin, RSTn, frm_strt, undr;

  i2s_tx #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .lft_in(lft_in), .rht_in(rht_in), .smpl_vld(smpl_vld),
    .smpl_rdy(smpl_rdy), .MCLK(MCLK), .SCLK(SCLK), .LRCLK(LRCLK), .SDin(SDin),
    .RSTn(RSTn), .frm_strt(frm_strt), .undr(undr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [9:0]  cnt_m = '0;
  bit          rstn_m, full_m, frm_m, undr_m, acc_m, capture_on;
  logic [31:0] hold_m = '0;
  logic [31:0] last_m = '0;
  logic [31:0] rx_sh = '0;
  int          nbits = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rx_q[$];
  logic [31:0] seen[$];

  // Advance one clock: apply the frame rules to the model, then decode SDin mid-bit.
  task automatic tick();
    logic        load;
    logic [31:0] w;
    load  = rstn_m && (cnt_m == 10'h1FF);
    acc_m = 1'b0;
    if (!rst) begin
      frm_m  = load;
      undr_m = 1'b0;
      if (load) begin
        if (full_m) begin
          w = hold_m;
          full_m = 1'b0;
        end else if (smpl_vld) begin
          w = {lft_in, rht_in};
          acc_m = 1'b1;
        end else begin
          undr_m = 1'b1;
          w = HOLD ? last_m : 32'h0;
        end
        last_m = w;
        exp_q.push_back(w);
      end else if (smpl_vld && !full_m) begin
        hold_m = {lft_in, rht_in};
        full_m = 1'b1;
        acc_m  = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      cnt_m = '0; rstn_m = 0; full_m = 0; frm_m = 0; undr_m = 0;
      last_m = '0; capture_on = 0; nbits = 0;
      exp_q.delete(); rx_q.delete();
    end else begin
      if (cnt_m == 10'h3FF) rstn_m = 1'b1;
      cnt_m = cnt_m + 10'd1;
      if (load) begin
        capture_on = 1'b1;
        nbits = 0;
      end else if (capture_on && cnt_m[4:0] == 5'h10) begin
        rx_sh = {rx_sh[30:0], SDin};
        nbits++;
        if (nbits == 32) begin
          rx_q.push_back(rx_sh);
          nbits = 0;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    smpl_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({MCLK, SCLK, LRCLK, SDin, RSTn, smpl_rdy, frm_strt, undr} !== 8'b0000_0100) begin
        failures++;
        $display("FAIL reset_outputs got=%b exp=%b", {MCLK, SCLK, LRCLK, SDin, RSTn, smpl_rdy, frm_strt, undr}, 8'b0000_0100);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 1023; i++) begin
      tick();
      checks++;
      if ({RSTn, SDin, frm_strt, MCLK, SCLK, LRCLK} !== {3'b000, cnt_m[1], cnt_m[4], cnt_m[9]}) begin
        failures++;
        $display("FAIL pre_rstn cycle=%0d got=%b exp=%b", i, {RSTn, SDin, frm_strt, MCLK, SCLK, LRCLK}, {3'b000, cnt_m[1], cnt_m[4], cnt_m[9]});
      end
    end
    tick();
    checks++;
    if (RSTn !== 1'b1) begin
      failures++;
      $display("FAIL rstn_rise got=%b exp=1", RSTn);
    end
  endtask

  task automatic test_stream();
    int g, n, pulses;
    logic [31:0] e, v;
    lft_in = 16'hA5C3; rht_in = 16'h7FFF; smpl_vld = 1'b1;
    g = 0;
    do begin tick(); g++; end while (!acc_m && g < 2048);
    smpl_vld = 1'b0;
    pulses = 0;
    for (int i = 0; i < 2048; i++) begin
      tick();
      checks++;
      if ({frm_strt, undr, smpl_rdy, LRCLK, SCLK, MCLK} !== {frm_m, undr_m, !full_m, cnt_m[9], cnt_m[4], cnt_m[1]}) begin
        failures++;
        $display("FAIL stream_ctrl got=%b exp=%b", {frm_strt, undr, smpl_rdy, LRCLK, SCLK, MCLK}, {frm_m, undr_m, !full_m, cnt_m[9], cnt_m[4], cnt_m[1]});
      end
      if (frm_strt) pulses++;
    end
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL frm_strt_rate got=%0d exp=2", pulses);
    end
    checks++;
    if (rx_q.size() == 0 || rx_q[0] !== 32'hA5C37FFF) begin
      failures++;
      $display("FAIL stream_first_frame got=%h exp=a5c37fff", (rx_q.size() == 0) ? 32'hx : rx_q[0]);
    end
    n = exp_q.size(); g = 0;
    while (rx_q.size() < n && g < 3000) begin tick(); g++; end
    checks++;
    if (rx_q.size() < n) begin failures++; $display("FAIL stream_wait got=%0d exp=%0d", rx_q.size(), n); end
    for (int i = 0; i < n && rx_q.size() > 0; i++) begin
      e = exp_q.pop_front(); v = rx_q.pop_front(); seen.push_back(v);
      checks++;
      if (v !== e) begin failures++; $display("FAIL stream_frame got=%h exp=%h", v, e); end
    end
  endtask

  task automatic test_bypass();
    int g, n;
    logic [15:0] l, r;
    logic [31:0] e, v;
    g = 0;
    while (cnt_m != 10'h1FF && g < 1100) begin tick(); g++; end
    l = 16'($urandom); r = 16'($urandom);
    lft_in = l; rht_in = r; smpl_vld = 1'b1;
    checks++;
    if (smpl_rdy !== 1'b1) begin failures++; $display("FAIL bypass_rdy_before got=%b exp=1", smpl_rdy); end
    tick();
    smpl_vld = 1'b0;
    checks++;
    if ({frm_strt, undr, smpl_rdy} !== 3'b101) begin
      failures++;
      $display("FAIL bypass_flags got=%b exp=101", {frm_strt, undr, smpl_rdy});
    end
    n = exp_q.size(); g = 0;
    while (rx_q.size() < n && g < 3000) begin tick(); g++; end
    checks++;
    if (rx_q.size() < n) begin failures++; $display("FAIL bypass_wait got=%0d exp=%0d", rx_q.size(), n); end
    for (int i = 0; i < n && rx_q.size() > 0; i++) begin
      e = exp_q.pop_front(); v = rx_q.pop_front(); seen.push_back(v);
      checks++;
      if (v !== e) begin failures++; $display("FAIL bypass_frame got=%h exp=%h", v, e); end
    end
    checks++;
    if (seen.size() == 0 || seen[$] !== {l, r}) begin
      failures++;
      $display("FAIL bypass_pair got=%h exp=%h", (seen.size() == 0) ? 32'hx : seen[$], {l, r});
    end
  endtask

  task automatic test_back_to_back();
    int g, n;
    logic [31:0] p1, p2, e, v;
    g = 0;
    while (cnt_m != 10'h050 && g < 1100) begin tick(); g++; end
    p1 = $urandom; p2 = $urandom;
    {lft_in, rht_in} = p1; smpl_vld = 1'b1;
    tick();
    checks++;
    if (smpl_rdy !== 1'b0) begin failures++; $display("FAIL b2b_full got=%b exp=0", smpl_rdy); end
    {lft_in, rht_in} = p2;
    g = 0;
    while (g < 1100) begin
      checks++;
      if (smpl_rdy !== !full_m) begin failures++; $display("FAIL b2b_stall got=%b exp=%b", smpl_rdy, !full_m); end
      tick(); g++;
      if (acc_m) break;
    end
    smpl_vld = 1'b0;
    checks++;
    if (smpl_rdy !== 1'b0) begin failures++; $display("FAIL b2b_p2_held got=%b exp=0", smpl_rdy); end
    g = 0;
    do begin tick(); g++; end while (!frm_m && g < 1100);
    n = exp_q.size(); g = 0;
    while (rx_q.size() < n && g < 3000) begin tick(); g++; end
    checks++;
    if (rx_q.size() < n) begin failures++; $display("FAIL b2b_wait got=%0d exp=%0d", rx_q.size(), n); end
    for (int i = 0; i < n && rx_q.size() > 0; i++) begin
      e = exp_q.pop_front(); v = rx_q.pop_front(); seen.push_back(v);
      checks++;
      if (v !== e) begin failures++; $display("FAIL b2b_frame got=%h exp=%h", v, e); end
    end
    checks++;
    if (seen.size() < 2 || seen[$-1] !== p1 || seen[$] !== p2) begin
      failures++;
      $display("FAIL b2b_order got=%h,%h exp=%h,%h", (seen.size() < 2) ? 32'hx : seen[$-1], (seen.size() == 0) ? 32'hx : seen[$], p1, p2);
    end
  endtask

  task automatic test_underrun();
    int g, n, pulses;
    logic [31:0] q, e, v, fill;
    g = 0;
    while (cnt_m != 10'h050 && g < 1100) begin tick(); g++; end
    lft_in = 16'h1234; rht_in = 16'h8000; smpl_vld = 1'b1;
    g = 0;
    do begin tick(); g++; end while (!acc_m && g < 1100);
    smpl_vld = 1'b0;
    g = 0;
    do begin tick(); g++; end while (!frm_m && g < 1100);
    pulses = 0;
    for (int i = 0; i < 1024; i++) begin
      tick();
      checks++;
      if (undr !== undr_m) begin failures++; $display("FAIL undr_pulse got=%b exp=%b", undr, undr_m); end
      if (undr) pulses++;
    end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL undr_count got=%0d exp=1", pulses); end
    q = $urandom;
    {lft_in, rht_in} = q; smpl_vld = 1'b1;
    g = 0;
    do begin tick(); g++; end while (!acc_m && g < 1100);
    smpl_vld = 1'b0;
    g = 0;
    do begin tick(); g++; end while (!frm_m && g < 1100);
    n = exp_q.size(); g = 0;
    while (rx_q.size() < n && g < 3000) begin tick(); g++; end
    checks++;
    if (rx_q.size() < n) begin failures++; $display("FAIL undr_wait got=%0d exp=%0d", rx_q.size(), n); end
    for (int i = 0; i < n && rx_q.size() > 0; i++) begin
      e = exp_q.pop_front(); v = rx_q.pop_front(); seen.push_back(v);
      checks++;
      if (v !== e) begin failures++; $display("FAIL undr_frame got=%h exp=%h", v, e); end
    end
    fill = HOLD ? 32'h12348000 : 32'h0;
    checks++;
    if (seen.size() < 3 || seen[$-2] !== 32'h12348000 || seen[$-1] !== fill || seen[$] !== q) begin
      failures++;
      $display("FAIL undr_sequence got=%h,%h,%h exp=12348000,%h,%h",
               (seen.size() < 3) ? 32'hx : seen[$-2], (seen.size() < 2) ? 32'hx : seen[$-1],
               (seen.size() == 0) ? 32'hx : seen[$], fill, q);
    end
  endtask

  task automatic test_random_stream();
    int g, n, gap;
    logic [31:0] e, v;
    for (int k = 0; k < 6; k++) begin
      gap = int'($urandom_range(0, 600));
      for (int i = 0; i < gap; i++) tick();
      {lft_in, rht_in} = $urandom; smpl_vld = 1'b1;
      g = 0;
      do begin tick(); g++; end while (!acc_m && g < 1100);
      smpl_vld = 1'b0;
      checks++;
      if (!acc_m) begin failures++; $display("FAIL rand_accept got=0 exp=1 pair=%0d", k); end
    end
    g = 0;
    do begin tick(); g++; end while (!frm_m && g < 1100);
    n = exp_q.size(); g = 0;
    while (rx_q.size() < n && g < 3000) begin tick(); g++; end
    checks++;
    if (rx_q.size() < n) begin failures++; $display("FAIL rand_wait got=%0d exp=%0d", rx_q.size(), n); end
    for (int i = 0; i < n && rx_q.size() > 0; i++) begin
      e = exp_q.pop_front(); v = rx_q.pop_front(); seen.push_back(v);
      checks++;
      if (v !== e) begin failures++; $display("FAIL rand_frame got=%h exp=%h", v, e); end
    end
  endtask

  task automatic test_mid_reset();
    int g;
    g = 0;
    while (cnt_m != 10'h050 && g < 1100) begin tick(); g++; end
    lft_in = 16'hFFFF; rht_in = 16'hFFFF; smpl_vld = 1'b1;
    tick();
    smpl_vld = 1'b0;
    g = 0;
    do begin tick(); g++; end while (!frm_m && g < 1100);
    while (cnt_m != 10'h250 && g < 2200) begin tick(); g++; end
    checks++;
    if (SDin !== 1'b1) begin failures++; $display("FAIL midrst_inflight got=%b exp=1", SDin); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({SDin, RSTn, smpl_rdy, frm_strt, undr, LRCLK, SCLK, MCLK} !== 8'b0010_0000) begin
      failures++;
      $display("FAIL midrst_state got=%b exp=00100000", {SDin, RSTn, smpl_rdy, frm_strt, undr, LRCLK, SCLK, MCLK});
    end
    for (int i = 0; i < 1023; i++) begin
      tick();
      checks++;
      if ({SDin, RSTn, frm_strt} !== 3'b000) begin
        failures++;
        $display("FAIL midrst_quiet cycle=%0d got=%b exp=000", i, {SDin, RSTn, frm_strt});
      end
    end
    tick();
    checks++;
    if (RSTn !== 1'b1) begin failures++; $display("FAIL midrst_rstn got=%b exp=1", RSTn); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_bypass();
    test_back_to_back();
    test_underrun();
    test_random_stream();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
